// File: rtl/map_write_scheduler_if.sv
// Map write scheduler bus: requester A/B handshakes, map RAM port and status.
// The o_Frame_Writes counter output exists only when MAP_WRITE_COUNT_EN is defined.
interface map_write_scheduler_if #(
  parameter int unsigned MAP_COLS = 20
);
  logic                i_VBlank;
  logic                i_Frame_Start;
  logic                i_A_Req;
  logic [4:0]          i_A_X;
  logic [3:0]          i_A_Y;
  logic                i_A_Tile;
  logic                i_B_Req;
  logic [3:0]          i_B_Row;
  logic [MAP_COLS-1:0] i_B_Data;
  logic                o_A_Ack;
  logic                o_B_Ack;
  logic                o_Err;
  logic                o_Rd_En;
  logic [3:0]          o_Rd_Row;
  logic [MAP_COLS-1:0] i_Rd_Data;
  logic                o_Wr_En;
  logic [3:0]          o_Wr_Row;
  logic [MAP_COLS-1:0] o_Wr_Data;
  logic                o_Busy;
`ifdef MAP_WRITE_COUNT_EN
  logic [7:0]          o_Frame_Writes;
`endif

  // Scheduler side
  modport slave (
    input  i_VBlank, i_Frame_Start,
    input  i_A_Req, i_A_X, i_A_Y, i_A_Tile,
    input  i_B_Req, i_B_Row, i_B_Data,
    input  i_Rd_Data,
    output o_A_Ack, o_B_Ack, o_Err,
    output o_Rd_En, o_Rd_Row,
    output o_Wr_En, o_Wr_Row, o_Wr_Data,
`ifdef MAP_WRITE_COUNT_EN
    output o_Frame_Writes,
`endif
    output o_Busy
  );

  // Requester / map RAM side
  modport master (
    output i_VBlank, i_Frame_Start,
    output i_A_Req, i_A_X, i_A_Y, i_A_Tile,
    output i_B_Req, i_B_Row, i_B_Data,
    output i_Rd_Data,
    input  o_A_Ack, o_B_Ack, o_Err,
    input  o_Rd_En, o_Rd_Row,
    input  o_Wr_En, o_Wr_Row, o_Wr_Data,
`ifdef MAP_WRITE_COUNT_EN
    input  o_Frame_Writes,
`endif
    input  o_Busy
  );
endinterface

// File: rtl/map_write_scheduler.sv
// Tile-map write scheduler: arbitrates a single-tile read-modify-write requester (A)
// and a full-row writer (B) round-robin, issuing map writes only from vertical blank.
// Optional MAP_WRITE_COUNT_EN adds a per-frame committed-write counter (o_Frame_Writes).
module map_write_scheduler #(
  parameter int unsigned MAP_COLS = 20,
  parameter int unsigned MAP_ROWS = 15
) (
  input logic                  i_Clk,
  input logic                  i_Reset,
  map_write_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StMerge, StWrite} state_e;

  state_e              state_q;
  logic                last_a_q;  // last grant went to A; reset to B so A wins first tie
  logic [4:0]          a_x_q;
  logic                a_tile_q;
  logic                a_ack_q;
  logic                b_ack_q;
  logic                err_q;
  logic                rd_en_q;
  logic [3:0]          rd_row_q;
  logic                wr_en_q;
  logic [3:0]          wr_row_q;
  logic [MAP_COLS-1:0] wr_data_q;

  logic                pick_a;
  logic                any_req;
  logic                a_bad;
  logic                b_bad;
  logic [MAP_COLS-1:0] merged;

  // Arbitration and range checks on the live request inputs
  always_comb begin
    any_req = bus.i_A_Req | bus.i_B_Req;
    pick_a  = bus.i_A_Req & (~bus.i_B_Req | ~last_a_q);
    a_bad   = (32'(bus.i_A_X) >= MAP_COLS) | (32'(bus.i_A_Y) >= MAP_ROWS);
    b_bad   = 32'(bus.i_B_Row) >= MAP_ROWS;
  end

  // Read data with the latched column replaced by the latched tile (bit 0 = leftmost)
  always_comb begin
    merged = bus.i_Rd_Data;
    for (int i = 0; i < MAP_COLS; i++) begin
      if (a_x_q == 5'(i)) begin
        merged[i] = a_tile_q;
      end
    end
  end

  // FSM with registered outputs; pulses default low and are set on state entry
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= StIdle;
      last_a_q  <= 1'b0;
      a_x_q     <= '0;
      a_tile_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_row_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_data_q <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_VBlank && any_req) begin
            last_a_q <= pick_a;
            if (pick_a) begin
              if (a_bad) begin
                // Out of range: ack with error, skip the map entirely
                a_ack_q <= 1'b1;
                err_q   <= 1'b1;
                state_q <= StWrite;
              end else begin
                a_x_q    <= bus.i_A_X;
                a_tile_q <= bus.i_A_Tile;
                rd_row_q <= bus.i_A_Y;
                rd_en_q  <= 1'b1;
                state_q  <= StRead;
              end
            end else begin
              b_ack_q <= 1'b1;
              if (b_bad) begin
                err_q <= 1'b1;
              end else begin
                wr_row_q  <= bus.i_B_Row;
                wr_data_q <= bus.i_B_Data;
                wr_en_q   <= 1'b1;
              end
              state_q <= StWrite;
            end
          end
        end
        StRead: begin
          // Map RAM returns the row during MERGE
          state_q <= StMerge;
        end
        StMerge: begin
          wr_data_q <= merged;
          wr_row_q  <= rd_row_q;
          wr_en_q   <= 1'b1;
          a_ack_q   <= 1'b1;
          state_q   <= StWrite;
        end
        StWrite: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MAP_WRITE_COUNT_EN
  logic [7:0] frame_writes_q;

  // Committed writes since the last frame start, saturating at 255
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      frame_writes_q <= '0;
    end else if (bus.i_Frame_Start) begin
      frame_writes_q <= wr_en_q ? 8'd1 : 8'd0;
    end else if (wr_en_q && (frame_writes_q != 8'hFF)) begin
      frame_writes_q <= frame_writes_q + 8'd1;
    end
  end

  assign bus.o_Frame_Writes = frame_writes_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = bus.i_Frame_Start;
`endif

  assign bus.o_A_Ack   = a_ack_q;
  assign bus.o_B_Ack   = b_ack_q;
  assign bus.o_Err     = err_q;
  assign bus.o_Rd_En   = rd_en_q;
  assign bus.o_Rd_Row  = rd_row_q;
  assign bus.o_Wr_En   = wr_en_q;
  assign bus.o_Wr_Row  = wr_row_q;
  assign bus.o_Wr_Data = wr_data_q;
  assign bus.o_Busy    = (state_q != StIdle);

endmodule

// File: tb/tb_map_write_scheduler.sv
// Directed testbench for map_write_scheduler: vector table of single-requester
// transactions plus hand-written sequences for tie, VBlank gating and reset.
module tb_map_write_scheduler;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  map_write_scheduler_if #(.MAP_COLS(20)) bus ();

  map_write_scheduler #(
    .MAP_COLS(20),
    .MAP_ROWS(15)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_req;
    logic [4:0]  a_x;
    logic [3:0]  a_y;
    logic        a_tile;
    logic        b_req;
    logic [3:0]  b_row;
    logic [19:0] b_data;
    logic [19:0] rd_data;
    int          lat;
    logic        exp_err;
    logic        exp_wr;
    logic [3:0]  exp_row;
    logic [19:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Clock until either ack appears, bounded
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.o_A_Ack || bus.o_B_Ack) && n < 12);
  endtask

  task automatic drop_reqs();
    bus.i_A_Req = 1'b0;
    bus.i_B_Req = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    n_tests = 0;
    n_fail  = 0;

    //             a_req x      y     t     b_req row    b_data     rd_data    lat err wr row  data
    vecs[0] = '{1'b1, 5'd3,  4'd2,  1'b0, 1'b0, 4'd0,  20'h00000, 20'hFFFFF, 3, 1'b0, 1'b1, 4'd2,
                20'hFFFF7};
    vecs[1] = '{1'b1, 5'd0,  4'd14, 1'b1, 1'b0, 4'd0,  20'h00000, 20'h00000, 3, 1'b0, 1'b1, 4'd14,
                20'h00001};
    vecs[2] = '{1'b1, 5'd19, 4'd7,  1'b1, 1'b0, 4'd0,  20'h00000, 20'h00000, 3, 1'b0, 1'b1, 4'd7,
                20'h80000};
    vecs[3] = '{1'b1, 5'd19, 4'd0,  1'b0, 1'b0, 4'd0,  20'h00000, 20'hFFFFF, 3, 1'b0, 1'b1, 4'd0,
                20'h7FFFF};
    vecs[4] = '{1'b0, 5'd0,  4'd0,  1'b0, 1'b1, 4'd5,  20'h12345, 20'h00000, 1, 1'b0, 1'b1, 4'd5,
                20'h12345};
    vecs[5] = '{1'b0, 5'd0,  4'd0,  1'b0, 1'b1, 4'd14, 20'hABCDE, 20'h00000, 1, 1'b0, 1'b1, 4'd14,
                20'hABCDE};
    vecs[6] = '{1'b1, 5'd20, 4'd0,  1'b1, 1'b0, 4'd0,  20'h00000, 20'h00000, 1, 1'b1, 1'b0, 4'd0,
                20'h00000};
    vecs[7] = '{1'b1, 5'd0,  4'd15, 1'b1, 1'b0, 4'd0,  20'h00000, 20'h00000, 1, 1'b1, 1'b0, 4'd0,
                20'h00000};
    vecs[8] = '{1'b0, 5'd0,  4'd0,  1'b0, 1'b1, 4'd15, 20'h11111, 20'h00000, 1, 1'b1, 1'b0, 4'd0,
                20'h00000};
    vecs[9] = '{1'b1, 5'd31, 4'd15, 1'b0, 1'b0, 4'd0,  20'h00000, 20'h00000, 1, 1'b1, 1'b0, 4'd0,
                20'h00000};

    bus.i_VBlank      = 1'b0;
    bus.i_Frame_Start = 1'b0;
    bus.i_A_Req       = 1'b0;
    bus.i_A_X         = '0;
    bus.i_A_Y         = '0;
    bus.i_A_Tile      = 1'b0;
    bus.i_B_Req       = 1'b0;
    bus.i_B_Row       = '0;
    bus.i_B_Data      = '0;
    bus.i_Rd_Data     = '0;
    rst               = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_busy",    32'(bus.o_Busy),    32'd0);
    check("rst_a_ack",   32'(bus.o_A_Ack),   32'd0);
    check("rst_b_ack",   32'(bus.o_B_Ack),   32'd0);
    check("rst_err",     32'(bus.o_Err),     32'd0);
    check("rst_rd_en",   32'(bus.o_Rd_En),   32'd0);
    check("rst_wr_en",   32'(bus.o_Wr_En),   32'd0);
    check("rst_rd_row",  32'(bus.o_Rd_Row),  32'd0);
    check("rst_wr_row",  32'(bus.o_Wr_Row),  32'd0);
    check("rst_wr_data", 32'(bus.o_Wr_Data), 32'd0);
    rst = 1'b0;
    tick();

    // Tie straight after reset: A first, then B
    bus.i_VBlank  = 1'b1;
    bus.i_A_Req   = 1'b1;
    bus.i_A_X     = 5'd1;
    bus.i_A_Y     = 4'd1;
    bus.i_A_Tile  = 1'b1;
    bus.i_Rd_Data = 20'h00000;
    bus.i_B_Req   = 1'b1;
    bus.i_B_Row   = 4'd3;
    bus.i_B_Data  = 20'h55555;
    wait_ack(n);
    check("tie_a_lat",   32'(n),             32'd3);
    check("tie_a_ack",   32'(bus.o_A_Ack),   32'd1);
    check("tie_b_ack0",  32'(bus.o_B_Ack),   32'd0);
    check("tie_a_data",  32'(bus.o_Wr_Data), 32'h00002);
    check("tie_a_row",   32'(bus.o_Wr_Row),  32'd1);
    bus.i_A_Req = 1'b0;
    wait_ack(n);
    check("tie_b_lat",   32'(n),             32'd2);
    check("tie_b_ack",   32'(bus.o_B_Ack),   32'd1);
    check("tie_b_wr_en", 32'(bus.o_Wr_En),   32'd1);
    check("tie_b_data",  32'(bus.o_Wr_Data), 32'h55555);
    check("tie_b_row",   32'(bus.o_Wr_Row),  32'd3);
    drop_reqs();
    tick();

    // VBlank falls, Req drops and payload changes after grant: transaction still completes
    bus.i_A_Req  = 1'b1;
    bus.i_A_X    = 5'd5;
    bus.i_A_Y    = 4'd4;
    bus.i_A_Tile = 1'b1;
    tick();
    check("vbf_rd_en",  32'(bus.o_Rd_En),  32'd1);
    check("vbf_rd_row", 32'(bus.o_Rd_Row), 32'd4);
    check("vbf_busy",   32'(bus.o_Busy),   32'd1);
    bus.i_VBlank = 1'b0;
    bus.i_A_Req  = 1'b0;
    bus.i_A_X    = 5'd9;
    bus.i_A_Y    = 4'd1;
    bus.i_A_Tile = 1'b0;
    tick();
    check("vbf_rd_en_off", 32'(bus.o_Rd_En), 32'd0);
    wait_ack(n);
    check("vbf_lat",     32'(n),             32'd1);
    check("vbf_ack",     32'(bus.o_A_Ack),   32'd1);
    check("vbf_data",    32'(bus.o_Wr_Data), 32'h00020);
    check("vbf_row",     32'(bus.o_Wr_Row),  32'd4);
    tick();
    check("vbf_idle",    32'(bus.o_Busy),    32'd0);

    // No grant while VBlank is low
    bus.i_VBlank = 1'b0;
    bus.i_B_Req  = 1'b1;
    bus.i_B_Row  = 4'd5;
    bus.i_B_Data = 20'h0F0F0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.o_Wr_En || bus.o_Busy || bus.o_B_Ack) cnt++;
    end
    check("novb_activity", 32'(cnt), 32'd0);
    bus.i_VBlank = 1'b1;
    wait_ack(n);
    check("vb_lat",   32'(n),             32'd1);
    check("vb_wr_en", 32'(bus.o_Wr_En),   32'd1);
    check("vb_ack",   32'(bus.o_B_Ack),   32'd1);
    check("vb_row",   32'(bus.o_Wr_Row),  32'd5);
    check("vb_data",  32'(bus.o_Wr_Data), 32'h0F0F0);
    drop_reqs();
    tick();

    // Table-driven single-requester transactions
    for (int v = 0; v < 10; v++) begin
      bus.i_VBlank  = 1'b1;
      bus.i_A_Req   = vecs[v].a_req;
      bus.i_A_X     = vecs[v].a_x;
      bus.i_A_Y     = vecs[v].a_y;
      bus.i_A_Tile  = vecs[v].a_tile;
      bus.i_B_Req   = vecs[v].b_req;
      bus.i_B_Row   = vecs[v].b_row;
      bus.i_B_Data  = vecs[v].b_data;
      bus.i_Rd_Data = vecs[v].rd_data;
      wait_ack(n);
      check($sformatf("v%0d_lat", v),   32'(n),           32'(vecs[v].lat));
      check($sformatf("v%0d_a_ack", v), 32'(bus.o_A_Ack), 32'(vecs[v].a_req));
      check($sformatf("v%0d_b_ack", v), 32'(bus.o_B_Ack), 32'(vecs[v].b_req));
      check($sformatf("v%0d_err", v),   32'(bus.o_Err),   32'(vecs[v].exp_err));
      check($sformatf("v%0d_wr_en", v), 32'(bus.o_Wr_En), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr) begin
        check($sformatf("v%0d_row", v),  32'(bus.o_Wr_Row),  32'(vecs[v].exp_row));
        check($sformatf("v%0d_data", v), 32'(bus.o_Wr_Data), 32'(vecs[v].exp_data));
      end
      drop_reqs();
      tick();
      check($sformatf("v%0d_pulse", v),
            32'({bus.o_Wr_En, bus.o_A_Ack, bus.o_B_Ack, bus.o_Err}), 32'd0);
      check($sformatf("v%0d_idle", v), 32'(bus.o_Busy), 32'd0);
    end

    // Reset during MERGE abandons the write
    bus.i_VBlank = 1'b1;
    bus.i_A_Req  = 1'b1;
    bus.i_A_X    = 5'd2;
    bus.i_A_Y    = 4'd3;
    bus.i_A_Tile = 1'b1;
    tick();
    tick();
    check("mrst_busy_pre", 32'(bus.o_Busy), 32'd1);
    rst         = 1'b1;
    bus.i_A_Req = 1'b0;
    tick();
    check("mrst_busy",  32'(bus.o_Busy),  32'd0);
    check("mrst_wr_en", 32'(bus.o_Wr_En), 32'd0);
    check("mrst_ack",   32'(bus.o_A_Ack), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_Wr_En || bus.o_A_Ack || bus.o_Busy) cnt++;
    end
    check("mrst_quiet", 32'(cnt), 32'd0);

`ifdef MAP_WRITE_COUNT_EN
    // Per-frame write counter saturation and clear
    bus.i_Frame_Start = 1'b1;
    tick();
    bus.i_Frame_Start = 1'b0;
    check("fw_clear0", 32'(bus.o_Frame_Writes), 32'd0);
    bus.i_VBlank = 1'b1;
    bus.i_B_Req  = 1'b1;
    bus.i_B_Row  = 4'd2;
    bus.i_B_Data = 20'h00001;
    cnt = 0;
    for (int i = 0; i < 620; i++) begin
      tick();
      if (bus.o_Wr_En) cnt++;
    end
    drop_reqs();
    tick();
    tick();
    check("fw_enough", 32'(cnt >= 300), 32'd1);
    check("fw_sat",    32'(bus.o_Frame_Writes), 32'd255);
    bus.i_Frame_Start = 1'b1;
    tick();
    bus.i_Frame_Start = 1'b0;
    check("fw_clear", 32'(bus.o_Frame_Writes), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
